// File: rtl/i2c_ctrl_pkg.sv
// Shared definitions for the I2C transaction arbiter.
//   arb_state_t     : FSM state encoding (also exported on the debug port)
//   DEF_*           : default field widths and timeout limits
//   max_int()       : constant-expression helper used to size the timeout counter
package i2c_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_LEN   = 7;
    localparam int DEF_DATA_LEN   = 8;
    localparam int DEF_LAUNCH_TMO = 16;
    localparam int DEF_TXN_TMO    = 4096;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester-side and master-side signals around the arbiter.
//   slave  modport : the arbiter's view (requests and m_free in, grants and m_* out)
//   master modport : the environment's view (requesters plus the I2C master)
//
// Handshake: req[i] is a level request. The arbiter answers with a one-hot
// gnt that stays high for the whole transaction, then exactly one of
// done[i]/err[i] pulses for one cycle while gnt[i] is still high. The
// requester drops req[i] by the cycle after that pulse; a req still high once
// the arbiter is back in IDLE counts as a fresh request. On the master side,
// m_start is held while the arbiter waits for m_free to fall, and a rising
// m_free afterwards marks the end of the transfer.
interface i2c_txn_arbiter_if
    import i2c_ctrl_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int DATA_LEN = DEF_DATA_LEN
);
    logic [1:0]            req;
    logic [2*ADDR_LEN-1:0] req_addr;
    logic [1:0]            req_rw;
    logic [2*DATA_LEN-1:0] req_data1;
    logic [2*DATA_LEN-1:0] req_data2;
    logic [1:0]            gnt;
    logic [1:0]            done;
    logic [1:0]            err;
    logic                  busy;
    logic                  m_start;
    logic [ADDR_LEN-1:0]   m_add_reg;
    logic                  m_r_w;
    logic [DATA_LEN-1:0]   m_data_1;
    logic [DATA_LEN-1:0]   m_data_2;
    logic                  m_free;

    modport slave (
        input  req, req_addr, req_rw, req_data1, req_data2, m_free,
        output gnt, done, err, busy, m_start, m_add_reg, m_r_w, m_data_1, m_data_2
    );

    modport master (
        output req, req_addr, req_rw, req_data1, req_data2, m_free,
        input  gnt, done, err, busy, m_start, m_add_reg, m_r_w, m_data_1, m_data_2
    );

endinterface

// File: rtl/i2c_rr_arbiter.sv
// Two-way round-robin pick.
//   req      : request vector, bit i = requester i
//   last_gnt : index of the requester served most recently
//   pick     : one-hot winner, zero when nobody requests
module i2c_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            // On a tie the requester that was not served last time wins.
            2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Arbitrates two requesters onto one I2C master and supervises each
// transaction with launch and completion timeouts.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : requester and master signals (slave modport)
//   dbg_state : current FSM state
module i2c_txn_arbiter
    import i2c_ctrl_pkg::*;
#(
    parameter int ADDR_LEN   = DEF_ADDR_LEN,
    parameter int DATA_LEN   = DEF_DATA_LEN,
    parameter int LAUNCH_TMO = DEF_LAUNCH_TMO,
    parameter int TXN_TMO    = DEF_TXN_TMO
) (
    input  logic                clk,
    input  logic                rst,
    i2c_txn_arbiter_if.slave    bus,
    output arb_state_t          dbg_state
);

    // One spare bit above the largest limit so the saturated value can never
    // alias back below a limit.
    localparam int CNT_W = $clog2(max_int(LAUNCH_TMO, TXN_TMO)) + 1;
    // The counter reads k during the (k+1)-th cycle in a state, so the limit
    // is reached on the LAUNCH_TMO-th / TXN_TMO-th cycle.
    localparam logic [CNT_W-1:0] LAUNCH_LIM = CNT_W'(LAUNCH_TMO - 1);
    localparam logic [CNT_W-1:0] TXN_LIM    = CNT_W'(TXN_TMO - 1);

    arb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    tmo_cnt_q;
    logic [1:0]          gnt_q, done_q, err_q, pick;
    logic                last_gnt_q;
    logic                grant_en, done_set, err_set;
    logic                sel;
    logic [ADDR_LEN-1:0] m_add_q;
    logic                m_rw_q;
    logic [DATA_LEN-1:0] m_d1_q, m_d2_q;

    i2c_rr_arbiter u_rr (
        .req      (bus.req),
        .last_gnt (last_gnt_q),
        .pick     (pick)
    );

    assign sel = pick[1];

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        done_set = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req != 2'b00 && bus.m_free) begin
                    grant_en = 1'b1;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // The master taking the request wins over a simultaneous timeout.
                if (!bus.m_free) begin
                    state_d = ST_ACTIVE;
                end else if (tmo_cnt_q >= LAUNCH_LIM) begin
                    err_set = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_ACTIVE: begin
                if (bus.m_free) begin
                    done_set = 1'b1;
                    state_d  = ST_RELEASE;
                end else if (tmo_cnt_q >= TXN_LIM) begin
                    err_set = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= '0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            last_gnt_q <= 1'b1;
            m_add_q    <= '0;
            m_rw_q     <= 1'b0;
            m_d1_q     <= '0;
            m_d2_q     <= '0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != '1) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end

            // Pulses land in the RELEASE cycle, where gnt is still held.
            done_q <= done_set ? gnt_q : 2'b00;
            err_q  <= err_set  ? gnt_q : 2'b00;

            if (grant_en) begin
                gnt_q   <= pick;
                m_add_q <= sel ? bus.req_addr[2*ADDR_LEN-1:ADDR_LEN]  : bus.req_addr[ADDR_LEN-1:0];
                m_rw_q  <= bus.req_rw[sel];
                m_d1_q  <= sel ? bus.req_data1[2*DATA_LEN-1:DATA_LEN] : bus.req_data1[DATA_LEN-1:0];
                m_d2_q  <= sel ? bus.req_data2[2*DATA_LEN-1:DATA_LEN] : bus.req_data2[DATA_LEN-1:0];
            end else if (state_q == ST_RELEASE) begin
                gnt_q      <= 2'b00;
                last_gnt_q <= gnt_q[1];
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.m_start   = (state_q == ST_LAUNCH);
    assign bus.m_add_reg = m_add_q;
    assign bus.m_r_w     = m_rw_q;
    assign bus.m_data_1  = m_d1_q;
    assign bus.m_data_2  = m_d2_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
- REQ-001: Parameter ADDR_LEN, default 7, slave address width.
- REQ-002: Parameter DATA_LEN, default 8, data byte width.
- REQ-003: Parameter LAUNCH_TMO, default 16, max cycles between m_start assertion and master leaving free.
- REQ-004: Parameter TXN_TMO, default 4096, max cycles between master leaving free and master returning to free.
- REQ-005: clk  input  1  the single clock; all logic on its rising edge.
- REQ-006: rst  input  1  reset, synchronous and active-high.
- REQ-007: req  input  2  level request per requester, bit i = requester i.
- REQ-008: req_addr  input  2*ADDR_LEN  slave address, slice i for requester i.
- REQ-009: req_rw  input  2  R_W bit per requester.
- REQ-010: req_data1  input  2*DATA_LEN  first data byte, slice i for requester i.
- REQ-011: req_data2  input  2*DATA_LEN  second data byte, slice i for requester i.
- REQ-012: gnt  output  2  one-hot grant, held for the whole transaction.
- REQ-013: done  output  2  one-cycle completion pulse to the granted requester.
- REQ-014: err  output  2  one-cycle timeout pulse to the granted requester.
- REQ-015: busy  output  1  high in every state except IDLE.
- REQ-016: m_start  output  1  start request to the I2C master.
- REQ-017: m_add_reg, m_r_w, m_data_1, m_data_2  output  ADDR_LEN/1/DATA_LEN/DATA_LEN  latched transaction fields to the master.
- REQ-018: m_free  input  1  master idle indication.

Function
- REQ-019: The FSM SHALL have states IDLE, LAUNCH, ACTIVE, RELEASE.
- REQ-020: In IDLE, with req != 0 and m_free = 1, the block SHALL grant one requester, latch its fields into m_* registers, assert gnt, and enter LAUNCH on the next edge.
- REQ-021: In IDLE with m_free = 0, no grant SHALL be issued.
- REQ-022: Arbitration SHALL be round-robin: on simultaneous requests the requester other than last_gnt wins; a single request wins regardless of last_gnt.
- REQ-023: Latency SHALL be one cycle: req sampled high in cycle N gives gnt and m_start high in cycle N+1.
- REQ-024: In LAUNCH, m_start SHALL be 1; m_free sampled 0 SHALL move the FSM to ACTIVE, and m_start SHALL be 0 from the next cycle.
- REQ-025: In LAUNCH, if m_free is still 1 after LAUNCH_TMO cycles, err[gnt] SHALL pulse and the FSM SHALL enter RELEASE.
- REQ-026: In ACTIVE, m_free sampled 1 SHALL pulse done[gnt] for one cycle and enter RELEASE.
- REQ-027: In ACTIVE, if m_free is still 0 after TXN_TMO cycles, err[gnt] SHALL pulse and the FSM SHALL enter RELEASE.
- REQ-028: done and err SHALL never both be asserted, and SHALL only assert on the bit set in gnt.
- REQ-029: RELEASE SHALL last exactly one cycle, clear gnt, update last_gnt to the served requester, and return to IDLE.
- REQ-030: m_* fields SHALL stay stable from the grant cycle through RELEASE, ignoring req_* changes and req deassertion.
- REQ-031: A requester SHALL deassert req in the cycle after done or err; a req still high in IDLE SHALL be treated as a new request.
- REQ-032: The timeout counter SHALL clear on every state entry, be $clog2(max(LAUNCH_TMO,TXN_TMO))+1 bits wide, and saturate rather than wrap.

Reset
- REQ-033: While rst = 1 at a clock edge, the block SHALL enter IDLE; gnt, done, err, busy and m_start SHALL be 0; m_* fields SHALL be 0; last_gnt SHALL be 1 so requester 0 wins the first tie.
- REQ-034: Reset mid-transaction SHALL abort with no done or err pulse.

Structure
- REQ-035: State encoding, ADDR_LEN/DATA_LEN defaults and timeout defaults SHALL live in shared package i2c_ctrl_pkg.
- REQ-036: The two-way round-robin pick SHALL be sub-module i2c_rr_arbiter (inputs req and last_gnt, output one-hot pick).

Verification
- REQ-037: req=01, addr0=0x50, rw0=0, d1=0xA5; m_free drops 3 cycles after m_start, returns after 100 cycles -> gnt=01 in cycle N+1, m_add_reg=0x50, done[0] pulses once, busy falls after RELEASE.
- REQ-038: req=11 from reset, then req=11 again -> first grant 01, second grant 10.
- REQ-039: req=10, m_free held 1 -> err[1] pulses after 16 LAUNCH cycles, with no done.
- REQ-040: m_free held 0 for 4096+ cycles in ACTIVE -> err pulses; the block then serves the next request.
- REQ-041: req_addr changes during ACTIVE -> m_add_reg unchanged; rst=1 mid-ACTIVE -> all outputs 0 next cycle, with no done or err.
